// File: rtl/usb_tx_line_encoder_pkg.sv
// Shared types and line-level constants for the USB transmit line encoder.
// Line levels are packed as {d_plus, d_minus}.
package usb_line_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DATA    = 2'd1,
        EOP_SE0 = 2'd2,
        EOP_J   = 2'd3
    } tx_state_e;

    localparam logic [1:0] LINE_J_FS = 2'b10;
    localparam logic [1:0] LINE_K_FS = 2'b01;
    localparam logic [1:0] LINE_SE0  = 2'b00;

    // Idle (J) level for the selected speed; low speed swaps the pair.
    function automatic logic [1:0] line_j(input logic low_speed);
        return low_speed ? LINE_K_FS : LINE_J_FS;
    endfunction

    // Opposite differential state (J <-> K); only meaningful for J or K.
    function automatic logic [1:0] line_toggle(input logic [1:0] lvl);
        return {lvl[0], lvl[1]};
    endfunction

endpackage

// File: rtl/usb_tx_line_encoder_if.sv
// Serial bit handshake between the TX packetiser (master) and the line
// encoder (slave).
interface usb_tx_line_encoder_if;
    logic tx_start;
    logic bit_data;
    logic bit_valid;
    logic bit_ready;
    logic tx_eop;

    modport master (
        output tx_start,
        output bit_data,
        output bit_valid,
        output tx_eop,
        input  bit_ready
    );

    modport slave (
        input  tx_start,
        input  bit_data,
        input  bit_valid,
        input  tx_eop,
        output bit_ready
    );
endinterface

// File: rtl/usb_tx_line_encoder_timer.sv
// Wrapping bit-period counter. Runs 0..PERIOD-1 while enabled, can be
// preloaded to its last count so the strobe fires on the very next cycle,
// and parks at 0 when not running. Also suitable for the RX sampler.
module usb_bit_timer #(
    parameter int unsigned PERIOD = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    input  logic load_last,
    output logic strobe
);
    localparam int unsigned CW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam logic [CW-1:0] LAST = CW'(PERIOD - 1);

    logic [CW-1:0] cnt_r;

    assign strobe = (cnt_r == LAST);

    // Bit-period counter: preload, wrap at the end of a bit, or park at zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r <= {CW{1'b0}};
        end else if (load_last) begin
            cnt_r <= LAST;
        end else if (!run) begin
            cnt_r <= {CW{1'b0}};
        end else if (strobe) begin
            cnt_r <= {CW{1'b0}};
        end else begin
            cnt_r <= cnt_r + CW'(1);
        end
    end
endmodule

// File: rtl/usb_tx_line_encoder.sv
// USB transmit line encoder: bit stuffing, NRZI, per-bit timing and a
// self-timed EOP, driving the D+/D- pair from registers.
module usb_tx_line_encoder
    import usb_line_pkg::*;
#(
    parameter int CLKS_PER_BIT = 8,
    parameter int STUFF_LEN    = 6,
    parameter int EOP_SE0_BITS = 2,
    parameter int LOW_SPEED    = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    usb_tx_line_encoder_if.slave  bus,
    output logic                  d_plus,
    output logic                  d_minus,
    output logic                  tx_active,
    output logic                  stuff_pulse,
    output logic                  eop_done,
    output logic                  err_underrun
);
    localparam int unsigned OW = $clog2(STUFF_LEN + 1);
    localparam int unsigned SW = $clog2(EOP_SE0_BITS + 1);
    localparam logic [OW-1:0] STUFF_MAX = OW'(STUFF_LEN);
    localparam logic [SW-1:0] SE0_LAST  = SW'(EOP_SE0_BITS - 1);
    localparam logic [1:0]    LINE_J    = line_j(LOW_SPEED != 0);

    if (CLKS_PER_BIT < 2) begin : g_bad_clks_per_bit
        $error("usb_tx_line_encoder: CLKS_PER_BIT must be >= 2");
    end
    if (STUFF_LEN < 1) begin : g_bad_stuff_len
        $error("usb_tx_line_encoder: STUFF_LEN must be >= 1");
    end
    if (EOP_SE0_BITS < 1) begin : g_bad_eop_se0_bits
        $error("usb_tx_line_encoder: EOP_SE0_BITS must be >= 1");
    end

    tx_state_e     state_r;
    logic [1:0]    line_r;
    logic [OW-1:0] ones_cnt_r;
    logic [SW-1:0] se0_cnt_r;
    logic          tx_active_r;
    logic          stuff_pulse_r;
    logic          eop_done_r;
    logic          err_underrun_r;

    logic strobe_s;
    logic stuff_due_s;
    logic start_s;

    assign start_s     = (state_r == IDLE) && bus.tx_start;
    assign stuff_due_s = (ones_cnt_r == STUFF_MAX);

    usb_bit_timer #(
        .PERIOD (CLKS_PER_BIT)
    ) u_bit_timer (
        .clk       (clk),
        .rst       (rst),
        .run       (state_r != IDLE),
        .load_last (start_s),
        .strobe    (strobe_s)
    );

    // Upstream bit is taken only at a DATA strobe that is not reserved for a stuffed bit.
    assign bus.bit_ready = (state_r == DATA) && strobe_s && !stuff_due_s;

    assign d_plus       = line_r[1];
    assign d_minus      = line_r[0];
    assign tx_active    = tx_active_r;
    assign stuff_pulse  = stuff_pulse_r;
    assign eop_done     = eop_done_r;
    assign err_underrun = err_underrun_r;

    // Packet FSM with registered line level, ones run length and status pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r        <= IDLE;
            line_r         <= LINE_J;
            ones_cnt_r     <= {OW{1'b0}};
            se0_cnt_r      <= {SW{1'b0}};
            tx_active_r    <= 1'b0;
            stuff_pulse_r  <= 1'b0;
            eop_done_r     <= 1'b0;
            err_underrun_r <= 1'b0;
        end else begin
            stuff_pulse_r  <= 1'b0;
            eop_done_r     <= 1'b0;
            err_underrun_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    line_r     <= LINE_J;
                    ones_cnt_r <= {OW{1'b0}};
                    se0_cnt_r  <= {SW{1'b0}};
                    if (bus.tx_start) begin
                        state_r     <= DATA;
                        tx_active_r <= 1'b1;
                    end else begin
                        tx_active_r <= 1'b0;
                    end
                end
                DATA: begin
                    if (strobe_s) begin
                        if (stuff_due_s) begin
                            // Stuffed 0 always toggles, even after the last data bit.
                            line_r        <= line_toggle(line_r);
                            ones_cnt_r    <= {OW{1'b0}};
                            stuff_pulse_r <= 1'b1;
                        end else if (bus.bit_valid) begin
                            if (bus.bit_data) begin
                                ones_cnt_r <= ones_cnt_r + OW'(1);
                            end else begin
                                line_r     <= line_toggle(line_r);
                                ones_cnt_r <= {OW{1'b0}};
                            end
                        end else if (bus.tx_eop) begin
                            state_r   <= EOP_SE0;
                            line_r    <= LINE_SE0;
                            se0_cnt_r <= {SW{1'b0}};
                        end else begin
                            // Starved mid-packet: flag it and close the packet cleanly.
                            err_underrun_r <= 1'b1;
                            state_r        <= EOP_SE0;
                            line_r         <= LINE_SE0;
                            se0_cnt_r      <= {SW{1'b0}};
                        end
                    end
                end
                EOP_SE0: begin
                    if (strobe_s) begin
                        if (se0_cnt_r == SE0_LAST) begin
                            state_r <= EOP_J;
                            line_r  <= LINE_J;
                        end else begin
                            se0_cnt_r <= se0_cnt_r + SW'(1);
                        end
                    end
                end
                EOP_J: begin
                    if (strobe_s) begin
                        state_r     <= IDLE;
                        tx_active_r <= 1'b0;
                        eop_done_r  <= 1'b1;
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    line_r      <= LINE_J;
                    tx_active_r <= 1'b0;
                end
            endcase
        end
    end
endmodule
